// File: rtl/column_mult_sequencer.sv
// column_mult_sequencer
// Feeds two latched square matrices to a downstream column multiplier one
// column at a time and gathers the returned product columns into out_c.
// Pure data routing: no arithmetic happens here.
//
// Ports:
//   in_clk, in_reset        clock, asynchronous active-low reset
//   in_start, in_a, in_b    host request and operand matrices
//   in_ack                  host acknowledge of the result
//   out_busy, out_done      status; out_c is the gathered product matrix
//   cm_a, cm_b, cm_ready    column operands and request to the multiplier
//   cm_c, cm_done, cm_ack   column result, result-valid and acknowledge
//
// Matrix element (r,c) lives at bits [(r*size+c)*cell_width +: cell_width];
// column slot r on cm_* buses is element (r, current column).
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | outputs low, waiting for in_start
// ISSUE | present column r_col with cm_ready, or finish when r_col == size
// WAIT  | operands held, waiting for cm_done
// ACK   | cm_ack held until cm_done is seen low
// DONE  | out_done high, result held until in_ack

module column_mult_sequencer #(
   parameter int size       = 4,
   parameter int cell_width = 32,
   parameter int col_width  = cell_width * size,
   parameter int mat_width  = cell_width * size * size
) (
   input  logic                 in_clk,
   input  logic                 in_reset,
   input  logic                 in_start,
   input  logic [mat_width-1:0] in_a,
   input  logic [mat_width-1:0] in_b,
   input  logic                 in_ack,
   output logic                 out_busy,
   output logic                 out_done,
   output logic [mat_width-1:0] out_c,
   output logic [col_width-1:0] cm_a,
   output logic [col_width-1:0] cm_b,
   output logic                 cm_ready,
   input  logic [col_width-1:0] cm_c,
   input  logic                 cm_done,
   output logic                 cm_ack
);

   localparam int col_bits = $clog2(size + 1);

   localparam logic [2:0] st_idle  = 3'd0;
   localparam logic [2:0] st_issue = 3'd1;
   localparam logic [2:0] st_wait  = 3'd2;
   localparam logic [2:0] st_ack   = 3'd3;
   localparam logic [2:0] st_done  = 3'd4;

   logic [2:0]           state;
   logic [mat_width-1:0] r_a;
   logic [mat_width-1:0] r_b;
   logic [col_bits-1:0]  r_col;
   logic                 last_col;
   logic [col_width-1:0] col_a;
   logic [col_width-1:0] col_b;
   logic [mat_width-1:0] c_merged;

   assign last_col = (r_col == col_bits'(size));

   // Column select from the latched matrices and scatter of the returned
   // column into the result. The index is clamped so the terminal count
   // value never produces an out-of-range slice.
   always_comb begin
      int col_i;
      col_a    = '0;
      col_b    = '0;
      c_merged = out_c;
      col_i    = last_col ? 0 : int'(r_col);
      for (int r = 0; r < size; r++) begin
         col_a[r*cell_width +: cell_width] = r_a[(r*size + col_i)*cell_width +: cell_width];
         col_b[r*cell_width +: cell_width] = r_b[(r*size + col_i)*cell_width +: cell_width];
         c_merged[(r*size + col_i)*cell_width +: cell_width] = cm_c[r*cell_width +: cell_width];
      end
   end

   always_ff @(posedge in_clk or negedge in_reset) begin
      if (!in_reset) begin
         state    <= st_idle;
         r_a      <= '0;
         r_b      <= '0;
         r_col    <= '0;
         out_busy <= 1'b0;
         out_done <= 1'b0;
         out_c    <= '0;
         cm_a     <= '0;
         cm_b     <= '0;
         cm_ready <= 1'b0;
         cm_ack   <= 1'b0;
      end else begin
         case (state)
            st_idle: begin
               out_busy <= 1'b0;
               out_done <= 1'b0;
               cm_a     <= '0;
               cm_b     <= '0;
               cm_ready <= 1'b0;
               cm_ack   <= 1'b0;
               r_col    <= '0;
               if (in_start) begin
                  r_a      <= in_a;
                  r_b      <= in_b;
                  out_c    <= '0;
                  out_busy <= 1'b1;
                  state    <= st_issue;
               end
            end
            st_issue: begin
               if (last_col) begin
                  out_done <= 1'b1;
                  state    <= st_done;
               end else begin
                  cm_a     <= col_a;
                  cm_b     <= col_b;
                  cm_ready <= 1'b1;
                  state    <= st_wait;
               end
            end
            st_wait: begin
               cm_ready <= 1'b0;
               if (cm_done) begin
                  out_c  <= c_merged;
                  cm_ack <= 1'b1;
                  state  <= st_ack;
               end
            end
            st_ack: begin
               // Leaving only once cm_done is low guarantees the multiplier
               // is idle before the next cm_ready.
               if (!cm_done) begin
                  cm_ack <= 1'b0;
                  r_col  <= r_col + 1'b1;
                  state  <= st_issue;
               end
            end
            st_done: begin
               if (in_ack) begin
                  out_done <= 1'b0;
                  out_busy <= 1'b0;
                  state    <= st_idle;
               end
            end
            default: state <= st_idle;
         endcase
      end
   end

endmodule

// File: tb/tb_column_mult_sequencer.sv
module tb_column_mult_sequencer;

   localparam int SZ   = 4;
   localparam int CW   = 32;
   localparam int COLW = CW * SZ;
   localparam int MW   = CW * SZ * SZ;

   logic            in_clk = 1'b0;
   logic            in_reset;
   logic            in_start;
   logic [MW-1:0]   in_a, in_b;
   logic            in_ack;
   logic            out_busy, out_done;
   logic [MW-1:0]   out_c;
   logic [COLW-1:0] cm_a, cm_b, cm_c;
   logic            cm_ready, cm_done, cm_ack;

   int n_assert = 0;
   int n_fail   = 0;

   // multiplier model controls and observations
   int            lat      = 5;
   int            stretch  = 0;
   int            ready_cnt = 0;
   int            job_base = 0;
   logic [MW-1:0] job_a, job_b;

   always #5 in_clk = ~in_clk;

   column_mult_sequencer #(.size(SZ), .cell_width(CW)) dut (
      .in_clk(in_clk), .in_reset(in_reset), .in_start(in_start),
      .in_a(in_a), .in_b(in_b), .in_ack(in_ack),
      .out_busy(out_busy), .out_done(out_done), .out_c(out_c),
      .cm_a(cm_a), .cm_b(cm_b), .cm_ready(cm_ready),
      .cm_c(cm_c), .cm_done(cm_done), .cm_ack(cm_ack)
   );

   task automatic check(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // single-precision multiply for normal operands, truncating rounding
   function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
      logic [47:0] m;
      int          e;
      m = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
      e = int'(a[30:23]) + int'(b[30:23]) - 127;
      if (m[47]) begin
         e++;
         return {a[31] ^ b[31], e[7:0], m[46:24]};
      end
      return {a[31] ^ b[31], e[7:0], m[45:23]};
   endfunction

   function automatic logic [31:0] int2f(input int n);
      int          p;
      logic [31:0] m;
      int          ex;
      p = 0;
      for (int i = 0; i < 31; i++) if (((n >> i) & 1) == 1) p = i;
      m  = 32'(n) << (23 - p);
      ex = 127 + p;
      return {1'b0, ex[7:0], m[22:0]};
   endfunction

   function automatic logic [31:0] rand_f();
      logic [7:0] ex;
      ex = 8'($urandom_range(150, 100));
      return {1'($urandom), ex, 23'($urandom)};
   endfunction

   function automatic logic [MW-1:0] rand_mat();
      logic [MW-1:0] m;
      for (int i = 0; i < SZ*SZ; i++) m[i*CW +: CW] = rand_f();
      return m;
   endfunction

   function automatic logic [MW-1:0] fill(input logic [31:0] v);
      logic [MW-1:0] m;
      for (int i = 0; i < SZ*SZ; i++) m[i*CW +: CW] = v;
      return m;
   endfunction

   function automatic logic [MW-1:0] hadamard(input logic [MW-1:0] a, input logic [MW-1:0] b);
      logic [MW-1:0] c;
      for (int i = 0; i < SZ*SZ; i++) c[i*CW +: CW] = fmul(a[i*CW +: CW], b[i*CW +: CW]);
      return c;
   endfunction

   // Behavioural column multiplier: captures on cm_ready, answers after lat
   // cycles, holds cm_done until it has seen cm_ack plus 'stretch' cycles.
   initial begin
      logic [COLW-1:0] col_ea, col_eb;
      int              col;
      bit              aborted;
      cm_done = 1'b0;
      cm_c    = '0;
      forever begin
         @(negedge in_clk);
         if (in_reset && cm_ready) begin
            col = ready_cnt - job_base;
            ready_cnt++;
            if (col < SZ) begin
               for (int r = 0; r < SZ; r++) begin
                  col_ea[r*CW +: CW] = job_a[(r*SZ + col)*CW +: CW];
                  col_eb[r*CW +: CW] = job_b[(r*SZ + col)*CW +: CW];
               end
               check("cm_a_column", MW'(cm_a), MW'(col_ea));
               check("cm_b_column", MW'(cm_b), MW'(col_eb));
            end
            for (int r = 0; r < SZ; r++)
               cm_c[r*CW +: CW] = fmul(cm_a[r*CW +: CW], cm_b[r*CW +: CW]);
            aborted = 1'b0;
            for (int i = 0; i < lat; i++) begin
               @(negedge in_clk);
               if (!in_reset) aborted = 1'b1;
            end
            if (!aborted) begin
               cm_done = 1'b1;
               for (int i = 0; i < 50; i++) begin
                  @(negedge in_clk);
                  if (cm_ack || !in_reset) break;
               end
               if (in_reset) begin
                  check("cm_ack_raised", MW'(cm_ack), MW'(1'b1));
                  for (int i = 0; i < stretch; i++) begin
                     @(negedge in_clk);
                     check("cm_ack_stretch", MW'(cm_ack), MW'(1'b1));
                  end
                  @(negedge in_clk);
               end
               cm_done = 1'b0;
            end
         end
      end
   end

   // protocol monitor
   initial begin
      forever begin
         @(negedge in_clk);
         if (in_reset && cm_ready) begin
            check("ready_without_ack", MW'(cm_ack), MW'(1'b0));
            check("ready_after_done_low", MW'(cm_done), MW'(1'b0));
         end
      end
   end

   task automatic start_job(input logic [MW-1:0] a, input logic [MW-1:0] b);
      job_a    = a;
      job_b    = b;
      job_base = ready_cnt;
      in_a     = a;
      in_b     = b;
      in_start = 1'b1;
      @(negedge in_clk);
      in_start = 1'b0;
      check("busy_after_accept", MW'(out_busy), MW'(1'b1));
      check("out_c_cleared", out_c, '0);
      check("no_ready_yet", MW'(cm_ready), MW'(1'b0));
      @(negedge in_clk);
      check("first_ready", MW'(cm_ready), MW'(1'b1));
   endtask

   task automatic finish_job(input logic [MW-1:0] exp, input int ack_delay);
      for (int i = 0; i < 400 && !out_done; i++) @(negedge in_clk);
      check("done_seen", MW'(out_done), MW'(1'b1));
      check("result", out_c, exp);
      check("ready_pulses", MW'(ready_cnt - job_base), MW'(SZ));
      check("busy_in_done", MW'(out_busy), MW'(1'b1));
      repeat (ack_delay) @(negedge in_clk);
      check("done_held", MW'(out_done), MW'(1'b1));
      check("result_held", out_c, exp);
      in_ack = 1'b1;
      @(negedge in_clk);
      in_ack = 1'b0;
      check("done_dropped", MW'(out_done), MW'(1'b0));
      check("busy_dropped", MW'(out_busy), MW'(1'b0));
      check("result_kept", out_c, exp);
   endtask

   initial begin
      logic [MW-1:0] a, b, a_seq, a2, b2;
      in_reset = 1'b0;
      in_start = 1'b0;
      in_ack   = 1'b0;
      in_a     = '0;
      in_b     = '0;
      repeat (2) @(negedge in_clk);
      check("rst_busy", MW'(out_busy), '0);
      check("rst_done", MW'(out_done), '0);
      check("rst_out_c", out_c, '0);
      check("rst_cm_a", MW'(cm_a), '0);
      check("rst_cm_ready", MW'(cm_ready), '0);
      check("rst_cm_ack", MW'(cm_ack), '0);
      in_reset = 1'b1;
      @(negedge in_clk);

      // 2.0 * 3.0 everywhere, long ack delay
      lat = 5; stretch = 0;
      start_job(fill(32'h4000_0000), fill(32'h4040_0000));
      finish_job(fill(32'h40C0_0000), 10);

      // column ordering: distinct integers times 1.0
      for (int i = 0; i < SZ*SZ; i++) a_seq[i*CW +: CW] = int2f(i + 1);
      lat = 3;
      start_job(a_seq, fill(32'h3F80_0000));
      finish_job(a_seq, 0);

      // stretched handshake plus ignored inputs and operand changes
      a = rand_mat(); b = rand_mat();
      lat = 2; stretch = 3;
      start_job(a, b);
      in_start = 1'b1; in_a = rand_mat(); in_b = rand_mat();
      @(negedge in_clk);
      in_start = 1'b0;
      for (int i = 0; i < 50 && !cm_ack; i++) @(negedge in_clk);
      for (int i = 0; i < 50 && cm_ack; i++) @(negedge in_clk);
      in_ack = 1'b1;
      @(negedge in_clk);
      in_ack = 1'b0;
      check("in_ack_ignored", MW'(out_busy), MW'(1'b1));
      finish_job(hadamard(a, b), 2);

      // back-to-back job: out_c must clear at accept
      a2 = rand_mat(); b2 = rand_mat();
      lat = 1; stretch = 1;
      start_job(a2, b2);
      finish_job(hadamard(a2, b2), 0);

      // asynchronous reset in the middle of WAIT
      lat = 8; stretch = 0;
      start_job(rand_mat(), rand_mat());
      repeat (2) @(negedge in_clk);
      #3 in_reset = 1'b0;
      #1;
      check("mid_rst_busy", MW'(out_busy), '0);
      check("mid_rst_out_c", out_c, '0);
      check("mid_rst_cm_a", MW'(cm_a), '0);
      check("mid_rst_cm_b", MW'(cm_b), '0);
      check("mid_rst_ready", MW'(cm_ready), '0);
      repeat (3) @(negedge in_clk);
      in_reset = 1'b1;
      @(negedge in_clk);

      // recovery from reset
      a = rand_mat(); b = rand_mat();
      lat = 4; stretch = 2;
      start_job(a, b);
      finish_job(hadamard(a, b), 1);

      repeat (3) @(negedge in_clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
